// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing controller slice.
//   - Opcode encodings understood by the shared 4-bit ALU
//   - is_legal_op(): tells whether an opcode can be sent to the ALU
//   - state_t: controller FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;

  // Only the eight opcodes above are implemented by the ALU. Anything else,
  // including 0000, is answered by the controller with the error flag set.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_ADDC) && (op <= OP_LSR);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// ---------------------------------------------------------------------------
// alu_rr_arb2
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   valid[1:0]  request lines (bit 0 = requester 0)
//   advance     pulse to hand priority to the other requester
//   grant[1:0]  one-hot grant, combinational from valid and the pointer
// ---------------------------------------------------------------------------
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // Pointer names the requester that wins a tie; 0 after reset.
  logic ptr;

  // Priority pointer flips each time the controller finishes serving a
  // transaction, so two always-valid requesters alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  // A lone requester always wins; only a tie consults the pointer.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one external combinational ALU between two requesters.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/ready                request handshake per requester
//   reqN_a/b/op/cin                 operands, opcode, carry-in
//   rspN_valid/ready                response handshake per requester
//   rspN_result/cout/of/err         ALU result, flags, illegal-opcode flag
//   alu_a/b/op/cin                  drive to the external ALU
//   alu_out/cout/of                 results from the external ALU
//   busy                            high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_cout,
  output logic             rsp0_of,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_cout,
  output logic             rsp1_of,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_of,
  output logic             busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       arb_valid, grant;
  logic             accept, advance;
  logic             owner_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [3:0]       op_q, cnt_q;
  logic             cin_q, cout_q, of_q, err_q;
  logic [WIDTH-1:0] win_a, win_b;
  logic [3:0]       win_op;
  logic             win_cin;

  // Requests are only visible to the arbiter while idle and out of reset,
  // so ready can never rise during EXEC/RESP or while rst_n is held low.
  assign arb_valid = (state_q == ST_IDLE && rst_n) ? {req1_valid, req0_valid} : 2'b00;

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (arb_valid),
    .advance (advance),
    .grant   (grant)
  );

  assign win_a   = grant[1] ? req1_a   : req0_a;
  assign win_b   = grant[1] ? req1_b   : req0_b;
  assign win_op  = grant[1] ? req1_op  : req0_op;
  assign win_cin = grant[1] ? req1_cin : req0_cin;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and every output. The ALU sees the latched operands only in
  // EXEC and zeros otherwise; response data is zero unless that requester's
  // rsp_valid is high, which keeps all outputs quiet in IDLE and reset.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    advance     = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp0_result = '0;
    rsp0_cout   = 1'b0;
    rsp0_of     = 1'b0;
    rsp0_err    = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_result = '0;
    rsp1_cout   = 1'b0;
    rsp1_of     = 1'b0;
    rsp1_err    = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 4'b0000;
    alu_cin     = 1'b0;
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          accept     = 1'b1;
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_d    = is_legal_op(win_op) ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        alu_cin = cin_q;
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!owner_q) begin
          rsp0_valid  = 1'b1;
          rsp0_result = result_q;
          rsp0_cout   = cout_q;
          rsp0_of     = of_q;
          rsp0_err    = err_q;
          if (rsp0_ready) begin
            advance = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          rsp1_valid  = 1'b1;
          rsp1_result = result_q;
          rsp1_cout   = cout_q;
          rsp1_of     = of_q;
          rsp1_err    = err_q;
          if (rsp1_ready) begin
            advance = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch on accept, settle countdown in EXEC, and result capture
  // on the last settle cycle. An illegal opcode skips EXEC, so its error
  // response is preloaded here at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'b0000;
      cin_q    <= 1'b0;
      cnt_q    <= 4'd0;
      result_q <= '0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      owner_q  <= grant[1];
      a_q      <= win_a;
      b_q      <= win_b;
      op_q     <= win_op;
      cin_q    <= win_cin;
      cnt_q    <= SETTLE_LOAD;
      result_q <= '0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
      err_q    <= !is_legal_op(win_op);
    end else if (state_q == ST_EXEC) begin
      if (cnt_q == 4'd0) begin
        result_q <= alu_out;
        cout_q   <= alu_cout;
        of_q     <= alu_of;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Bench for alu_share_ctrl with a behavioural 4-bit ALU beside it.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = 0, req0_b = 0, req0_op = 0, req1_a = 0, req1_b = 0, req1_op = 0;
  logic       req0_cin = 0, req1_cin = 0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 0, rsp1_ready = 0;
  logic [3:0] rsp0_result, rsp1_result;
  logic       rsp0_cout, rsp0_of, rsp0_err, rsp1_cout, rsp1_of, rsp1_err;
  logic [3:0] alu_a, alu_b, alu_op, alu_out;
  logic       alu_cin, alu_cout, alu_of;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rq;
    logic [3:0] a, b, op;
    logic       cin;
    logic [3:0] res;
    logic       cout, of, err;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_cout(rsp0_cout), .rsp0_of(rsp0_of), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_cout(rsp1_cout), .rsp1_of(rsp1_of), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_of(alu_of),
    .busy(busy)
  );

  // Behavioural ALU: carry is the carry out of the 4-bit adder (for SUB
  // that means "no borrow"), overflow is signed overflow, LSR shifts out
  // into carry.
  always_comb begin
    logic [4:0] sum;
    sum      = 5'd0;
    alu_out  = 4'd0;
    alu_cout = 1'b0;
    alu_of   = 1'b0;
    case (alu_op)
      4'b0001, 4'b0010: begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, (alu_op == 4'b0001) & alu_cin};
        alu_out  = sum[3:0];
        alu_cout = sum[4];
        alu_of   = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      4'b0011: begin
        sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_out  = sum[3:0];
        alu_cout = sum[4];
        alu_of   = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      4'b0100: alu_out = alu_a & alu_b;
      4'b0101: alu_out = ~(alu_a | alu_b);
      4'b0110: alu_out = ~(alu_a ^ alu_b);
      4'b0111: alu_out = ~alu_a;
      4'b1000: begin alu_out = alu_a >> 1; alu_cout = alu_a[0]; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic who, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] op, input logic cin);
    if (!who) begin
      req0_a = a; req0_b = b; req0_op = op; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_cin = cin; req1_valid = 1'b1;
    end
  endtask

  // Called at the sample point of the cycle after accept; returns the cycle
  // index (1 = that cycle) on which rsp valid is first seen, 0 on timeout.
  task automatic waitRsp(input logic who, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (who ? rsp1_valid : rsp0_valid) begin
        lat = i;
        break;
      end
      checkOutput("no_ready_while_busy", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    checkOutput("rsp_arrived", (lat != 0), 1);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(v.rq, v.a, v.b, v.op, v.cin);
    #1;
    checkOutput("accept_ready", v.rq ? req1_ready : req0_ready, 1);
    if (v.err) checkOutput("illegal_alu_op_accept", alu_op, 0);
    @(posedge clk); #1;
    if (!v.rq) req0_valid = 1'b0; else req1_valid = 1'b0;
    waitRsp(v.rq, lat);
    if (lat != 0) begin
      checkOutput("latency", lat, v.lat);
      checkOutput("result", v.rq ? rsp1_result : rsp0_result, v.res);
      checkOutput("cout", v.rq ? rsp1_cout : rsp0_cout, v.cout);
      checkOutput("of", v.rq ? rsp1_of : rsp0_of, v.of);
      checkOutput("err", v.rq ? rsp1_err : rsp0_err, v.err);
      checkOutput("other_rsp_quiet", v.rq ? rsp0_valid : rsp1_valid, 0);
      if (v.err) checkOutput("illegal_alu_op_resp", alu_op, 0);
    end
    @(posedge clk); #1;
    checkOutput("idle_after_handshake", busy, 0);
  endtask

  initial begin
    int lat;
    logic w;

    //           rq    a      b      op     cin  res    cout  of    err  lat
    vecs[0] = '{1'b0, 4'h3, 4'h3, 4'h2, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b1, 4'h6, 4'h9, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 4'h5, 4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 2};
    vecs[3] = '{1'b0, 4'hC, 4'hA, 4'h6, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 2};
    vecs[4] = '{1'b1, 4'h3, 4'h0, 4'h7, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 2};
    vecs[5] = '{1'b0, 4'hA, 4'h0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{1'b1, 4'h3, 4'h5, 4'h3, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 2};
    vecs[7] = '{1'b1, 4'h5, 4'h7, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1};
    vecs[8] = '{1'b0, 4'h7, 4'h1, 4'h2, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 2};

    // Reset state, with a request pending that must not be acknowledged.
    req0_valid = 1'b1;
    req0_op    = 4'h2;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", {req1_ready, req0_ready}, 0);
    checkOutput("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    checkOutput("reset_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters held valid: grants alternate 0,1,0,1 from reset.
    $display("[TB] fairness sequence");
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b0, 4'h7, 4'h6, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h7, 4'hA, 4'h4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      w = k[0];
      #1;
      checkOutput("fair_grant", {req1_ready, req0_ready}, w ? 2 : 1);
      @(posedge clk); #1;
      waitRsp(w, lat);
      if (lat != 0) begin
        checkOutput("fair_latency", lat, 2);
        checkOutput("fair_result", w ? rsp1_result : rsp0_result, w ? 4'h2 : 4'h1);
        checkOutput("fair_cout", w ? rsp1_cout : rsp0_cout, w ? 0 : 1);
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Directed single-requester vectors; ends with a req0 transaction.
    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) runVector(vecs[i]);

    // After serving req0, a tie must now go to req1.
    applyStimulus(1'b0, 4'h1, 4'h1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h4, 4'h2, 4'h2, 1'b0);
    #1;
    checkOutput("tie_prefers_req1", {req1_ready, req0_ready}, 2);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitRsp(1'b1, lat);
    if (lat != 0) checkOutput("tie_result", rsp1_result, 4'h6);
    @(posedge clk); #1;

    // Response back-pressure: result and busy held, no new accept.
    $display("[TB] back-pressure sequence");
    rsp0_ready = 1'b0;
    applyStimulus(1'b0, 4'hA, 4'h0, 4'h8, 1'b0);
    #1;
    checkOutput("bp_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    waitRsp(1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", rsp0_valid, 1);
      checkOutput("bp_result", rsp0_result, 4'h5);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_released", {busy, rsp0_valid}, 0);

    // Async reset during EXEC drops the transaction and the pointer.
    // Pointer is 1 here, so a tie after reset proves it returned to 0.
    $display("[TB] reset during EXEC");
    applyStimulus(1'b0, 4'h1, 4'h1, 4'h2, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checkOutput("exec_alu_op", alu_op, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_alu", {alu_a, alu_b, alu_op}, 0);
    checkOutput("async_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("no_rsp_after_reset", {rsp1_valid, rsp0_valid}, 0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 4'h2, 4'h3, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h1, 4'h1, 4'h4, 1'b0);
    #1;
    checkOutput("ptr_reset_grant", {req1_ready, req0_ready}, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitRsp(1'b0, lat);
    if (lat != 0) checkOutput("post_reset_result", rsp0_result, 4'h5);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
